// File: rtl/if_mem_fetch.sv
// Instruction-fill responder: wins the byte-wide RAM port, reads four bytes and
// returns them as one little-endian word with a single-cycle inst_ok pulse.
module if_mem_fetch #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_fe,
    input  logic [ADDR_W-1:0] inst_fpc,
    output logic [INST_W-1:0] inst,
    output logic              inst_ok,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [7:0]        mem_din,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] RECV = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] req_pc;
    logic [2:0]        cnt;
    logic [1:0]        byte_idx;

    // cnt counts edges since acceptance; byte k lands three edges after its address.
    assign byte_idx = 2'(cnt - 3'd2);
    assign busy     = (state != IDLE);

    always_comb begin
        mem_req = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:       mem_req = inst_fe;
                ADDR, RECV: mem_req = 1'b1;
                default:    mem_req = 1'b0;
            endcase
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            req_pc  <= '0;
            cnt     <= '0;
            mem_a   <= '0;
            inst    <= '0;
            inst_ok <= 1'b0;
            inst_pc <= '0;
        end else begin
            inst_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_fe && mem_gnt) begin
                        req_pc <= {inst_fpc[ADDR_W-1:2], 2'b00};
                        mem_a  <= {inst_fpc[ADDR_W-1:2], 2'b00};
                        cnt    <= '0;
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    mem_a <= mem_a + ADDR_W'(1);
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd2) begin
                        inst[7:0] <= mem_din;
                        state     <= RECV;
                    end
                end
                RECV: begin
                    inst[8*byte_idx +: 8] <= mem_din;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd5) begin
                        inst_ok <= 1'b1;
                        inst_pc <= req_pc;
                        state   <= DONE;
                    end
                end
                default: begin
                    // inst_fe seen here is stale, so DONE always returns to IDLE.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/if_mem_fetch.md
Name: if_mem_fetch

Overview:
- Responder side of the IF-stage instruction-fill interface (inst_fe / inst_fpc in; inst / inst_ok / inst_pc out).
- Sits between the IF stage and the memory arbiter in front of the byte-wide synchronous RAM.
- On a fill request, it wins the memory port, reads four consecutive bytes, and assembles them little-endian into one 32-bit word.
- It returns the word with a one-cycle inst_ok pulse, tagged with the word's address, so IF can fill its I-cache and/or unstall.

Parameters:
- ADDR_W, 32, width of instruction and memory addresses.
- INST_W, 32, instruction width; fixed at 4 bytes.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- inst_fe  in  1  fill request from IF; level, not pulse.
- inst_fpc  in  ADDR_W  address to fill; bits [1:0] are ignored and treated as 0.
- inst  out  INST_W  assembled instruction word.
- inst_ok  out  1  one-cycle pulse: inst/inst_pc are valid.
- inst_pc  out  ADDR_W  word-aligned address of inst.
- mem_req  out  1  memory port request to the arbiter.
- mem_gnt  in  1  arbiter grant; sampled only in IDLE.
- mem_a  out  ADDR_W  registered RAM byte address.
- mem_din  in  8  RAM read data, valid the cycle after the RAM samples mem_a.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE; inst=0, inst_ok=0, inst_pc=0, mem_a=0, mem_req=0, busy=0; internal req_pc=0, byte counter=0.
- An rst assertion in mid-transaction aborts immediately. No inst_ok is issued for the aborted fetch.
- States: IDLE, ADDR, RECV, DONE.
- IDLE:
  - mem_req = inst_fe (combinational).
  - Accept when inst_fe && mem_gnt at a posedge (edge T). At edge T:
    - req_pc <= {inst_fpc[ADDR_W-1:2],2'b00}
    - mem_a <= req address + 0
    - go to ADDR
- ADDR / RECV pipeline:
  - mem_a steps +1 on each of the edges T+1, T+2, T+3, giving byte addresses +1..+3. It then holds.
  - The RAM samples each address one edge after mem_a updates. Byte k is therefore on mem_din during the cycle after edge T+2+k.
  - Byte k is captured into inst[8k+7:8k] at edge T+3+k, k=0..3.
  - The state is ADDR until the last address is issued, then RECV until byte 3 is captured.
- DONE:
  - Entered at edge T+6. inst_ok=1 for exactly that one cycle, inst_pc=req_pc, inst holds the full word.
  - Fixed latency: request accepted at edge T -> inst_ok high in the cycle following edge T+6.
  - Return to IDLE at the next edge.
  - No new request is accepted in the DONE cycle. IF's cache tag is written on that edge, so inst_fe seen during DONE is stale.
- inst and inst_pc keep their last values after DONE until the next capture. inst_ok is 0 outside DONE.
- mem_req:
  - Held 1 from acceptance until byte 3 is captured, regardless of mem_gnt.
  - The arbiter must not revoke a grant mid-transaction. mem_gnt outside IDLE is ignored.
- Redirect mid-fetch: changes to inst_fe or inst_fpc after acceptance are ignored.
  - The fetch completes and reports inst_pc=req_pc; IF discards it by address compare, and the cache fill is still useful.
  - A new request is evaluated on return to IDLE.
- inst_fe && !mem_gnt in IDLE: keep mem_req high, remain in IDLE; no state change.
- Address arithmetic: byte addresses are req_pc+0..+3 in ADDR_W bits. Because req_pc is word-aligned, the carry never leaves bits [1:0], so the top word (e.g. 0xFFFFFFFC -> ...FF) never wraps.
- busy = (state != IDLE).

Test Plan:
- Basic fill, RAM[0x100..0x103]=13,00,10,93; inst_fe=1, inst_fpc=0x100, mem_gnt=1 -> mem_a sequence 0x100..0x103; inst_ok pulses once, 6 cycles after accept; inst=0x93100013 (little-endian), inst_pc=0x100.
- Grant delay: inst_fe=1 with mem_gnt=0 for 3 cycles, then 1 -> mem_req=1 throughout and mem_a unchanged before the grant; inst_ok exactly 6 cycles after the grant edge.
- Redirect mid-fetch: inst_fpc changes 0x200->0x300 two cycles after accept -> inst_ok with inst_pc=0x200 and word from 0x200; next accept in IDLE uses 0x300; no acceptance during the DONE cycle.
- Unaligned and top address: inst_fpc=0xFFFFFFFE -> mem_a=0xFFFFFFFC..0xFFFFFFFF, inst_pc=0xFFFFFFFC.
- Async reset mid-fetch: assert rst between clock edges after byte 1 is captured -> all outputs 0 immediately; no inst_ok; a fresh fetch after release behaves as in the basic fill.
- Back-to-back: inst_fe held high with inst_fpc stepping 0x0, 0x4 after each inst_ok -> inst_ok pulses spaced exactly 8 cycles (accept..DONE 7, plus IDLE accept); words correct.
